// File: rtl/alu16_accum_datapath.sv
// ---------------------------------------------------------------------------
// alu16_accum_datapath
// WIDTH-bit combinational ALU (12 operations) feeding an accumulator register
// with registered carry and signed-overflow flags. The one-hot decode of the
// opcode is exported combinationally.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   a         operand A (sole operand for NOT / shifts)
//   b         operand B
//   opcode    4-bit operation code
//   select    12-bit one-hot operation decode (combinational from opcode)
//   result    accumulator register
//   carry     registered carry-out of ADD/SUB (1 = no borrow for SUB)
//   overflow  registered signed overflow of ADD/SUB
// ---------------------------------------------------------------------------
module alu16_accum_datapath #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [11:0]      select,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned SEL_W = 12;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOT   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NAND  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0110;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SEL_W-1:0] select_d;

  // Opcode decode; every unused code folds onto the CLEAR bit so select stays one-hot
  always_comb begin
    select_d = '0;
    case (opcode)
      OP_AND:  select_d[0]  = 1'b1;
      OP_OR:   select_d[1]  = 1'b1;
      OP_NOT:  select_d[2]  = 1'b1;
      OP_XOR:  select_d[3]  = 1'b1;
      OP_NAND: select_d[4]  = 1'b1;
      OP_NOR:  select_d[5]  = 1'b1;
      OP_XNOR: select_d[6]  = 1'b1;
      OP_ADD:  select_d[7]  = 1'b1;
      OP_SUB:  select_d[8]  = 1'b1;
      OP_SHR:  select_d[9]  = 1'b1;
      OP_SHL:  select_d[10] = 1'b1;
      default: select_d[11] = 1'b1;
    endcase
  end

  assign select = select_d;

  // Shared adder: SUB is a + ~b + 1, so one carry chain serves both
  assign is_sub  = (opcode == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + SUM_W'(is_sub);
  assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // ALU result and flags presented to the accumulator
  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (opcode)
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_NOT:  result_d = ~a;
      OP_XOR:  result_d = a ^ b;
      OP_NAND: result_d = ~(a & b);
      OP_NOR:  result_d = ~(a | b);
      OP_XNOR: result_d = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = add_ovf;
      end
      OP_SHR:  result_d = {1'b0, a[WIDTH-1:1]};
      OP_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
      default: result_d = '0;
    endcase
  end

  // Accumulator and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu16_accum_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu16_accum_datapath
// Scoreboard bench: each applied vector pushes its expected register contents
// (from an integer-arithmetic reference model) and the entry is popped and
// compared one rising edge later.
// ---------------------------------------------------------------------------
module tb_alu16_accum_datapath;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  opcode;
  logic [11:0] select;
  logic [15:0] result;
  logic        carry;
  logic        overflow;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  alu16_accum_datapath #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .select   (select),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model using plain integer arithmetic
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [3:0] op);
    exp_t e;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   s;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    e.r = 16'h0000;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      4'h0: e.r = ia & ib;
      4'h1: e.r = ia | ib;
      4'h2: e.r = ~ia;
      4'h3: e.r = ia ^ ib;
      4'h4: e.r = ~(ia & ib);
      4'h5: e.r = ~(ia | ib);
      4'h6: e.r = ~(ia ^ ib);
      4'h8: begin
        s   = ua + ub;
        e.r = 16'(s);
        e.c = (s > 65535);
        e.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'h9: begin
        e.r = 16'(ua - ub);
        e.c = (ua >= ub);
        e.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      4'hA: e.r = 16'(ua / 2);
      4'hB: e.r = 16'(ua * 2);
      default: e.r = 16'h0000;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] model_sel(input logic [3:0] op);
    case (op)
      4'h0: return 12'h001;
      4'h1: return 12'h002;
      4'h2: return 12'h004;
      4'h3: return 12'h008;
      4'h4: return 12'h010;
      4'h5: return 12'h020;
      4'h6: return 12'h040;
      4'h8: return 12'h080;
      4'h9: return 12'h100;
      4'hA: return 12'h200;
      4'hB: return 12'h400;
      default: return 12'h800;
    endcase
  endfunction

  // Apply a vector on the falling edge and record what the next rising edge must load
  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] op);
    @(negedge clk);
    a      = ia;
    b      = ib;
    opcode = op;
    sb_q.push_back(model(ia, ib, op));
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n  = 1'b0;
    a      = 16'hFFFF;
    b      = 16'h0002;
    opcode = 4'h8;
    #3;
    n_cmp++;
    if ({result, carry, overflow} !== 18'h0) begin
      $display("FAIL reset_initial: got %h/%b/%b want 0000/0/0", result, carry, overflow);
      n_bad++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, carry, overflow} !== 18'h0) begin
      $display("FAIL reset_held_through_edges: got %h/%b/%b want 0000/0/0", result, carry, overflow);
      n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(a, b, opcode));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({result, carry, overflow} !== {e.r, e.c, e.v}) begin
      $display("FAIL reset_release: got %h/%b/%b want %h/%b/%b", result, carry, overflow, e.r, e.c, e.v);
      n_bad++;
    end
    // Mid-cycle asynchronous reset clears without waiting for an edge
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({result, carry, overflow} !== 18'h0) begin
      $display("FAIL reset_async_mid_cycle: got %h/%b/%b want 0000/0/0", result, carry, overflow);
      n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(a, b, opcode));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({result, carry, overflow} !== {e.r, e.c, e.v}) begin
      $display("FAIL reset_rerelease: got %h/%b/%b want %h/%b/%b", result, carry, overflow, e.r, e.c, e.v);
      n_bad++;
    end
  endtask

  task automatic test_logic();
    logic [15:0] ta [7] = '{16'hC001, 16'h0002, 16'h4002, 16'h4002, 16'h0002, 16'h0002, 16'h0002};
    logic [15:0] tb [7] = '{16'h8001, 16'h0001, 16'h0000, 16'h0003, 16'h0003, 16'h0003, 16'h0003};
    logic [15:0] tr [7] = '{16'h8001, 16'h0003, 16'hBFFD, 16'h4001, 16'hFFFD, 16'hFFFC, 16'hFFFE};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive(ta[i], tb[i], 4'(i));
      #1;
      n_cmp++;
      if (select !== model_sel(4'(i))) begin
        $display("FAIL logic_select op=%0d: got %h want %h", i, select, model_sel(4'(i)));
        n_bad++;
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({result, carry, overflow} !== {tr[i], 1'b0, 1'b0} ||
          {result, carry, overflow} !== {e.r, e.c, e.v}) begin
        $display("FAIL logic op=%0d: got %h/%b/%b want %h/0/0", i, result, carry, overflow, tr[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_arith();
    logic [15:0] ta [4] = '{16'h0002, 16'h0002, 16'h7FFF, 16'hFFFF};
    logic [15:0] tb [4] = '{16'h0003, 16'h0003, 16'h0001, 16'h0001};
    logic [3:0]  to [4] = '{4'h8, 4'h9, 4'h8, 4'h8};
    logic [17:0] tx [4] = '{{16'h0005, 2'b00}, {16'hFFFF, 2'b00},
                            {16'h8000, 2'b01}, {16'h0000, 2'b10}};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], to[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({result, carry, overflow} !== tx[i] || {result, carry, overflow} !== {e.r, e.c, e.v}) begin
        $display("FAIL arith case %0d: got %h/%b/%b want %h/%b/%b",
                 i, result, carry, overflow, tx[i][17:2], tx[i][1], tx[i][0]);
        n_bad++;
      end
    end
  endtask

  task automatic test_shift();
    logic [15:0] ta [4] = '{16'h0002, 16'h0002, 16'h8001, 16'h8001};
    logic [3:0]  to [4] = '{4'hA, 4'hB, 4'hB, 4'hA};
    logic [15:0] tr [4] = '{16'h0001, 16'h0004, 16'h0002, 16'h4000};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], 16'hFFFF, to[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({result, carry, overflow} !== {tr[i], 2'b00} || result !== e.r) begin
        $display("FAIL shift case %0d: got %h/%b/%b want %h/0/0", i, result, carry, overflow, tr[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] to [7] = '{4'h8, 4'hF, 4'h8, 4'hD, 4'h7, 4'hC, 4'hE};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive(16'h0002, 16'h0003, to[i]);
      #1;
      n_cmp++;
      if (select !== model_sel(to[i])) begin
        $display("FAIL clear_select op=%h: got %h want %h", to[i], select, model_sel(to[i]));
        n_bad++;
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({result, carry, overflow} !== {e.r, e.c, e.v}) begin
        $display("FAIL clear op=%h: got %h/%b/%b want %h/%b/%b",
                 to[i], result, carry, overflow, e.r, e.c, e.v);
        n_bad++;
      end
    end
    drive(16'h0002, 16'h0003, 4'h9);
    #1;
    n_cmp++;
    if (select !== 12'h100) begin
      $display("FAIL sub_select: got %h want 100", select);
      n_bad++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({result, carry, overflow} !== {e.r, e.c, e.v}) begin
      $display("FAIL sub_after_clear: got %h/%b/%b want %h/%b/%b", result, carry, overflow, e.r, e.c, e.v);
      n_bad++;
    end
  endtask

  task automatic test_latency_hold();
    exp_t e;
    drive(16'h1234, 16'h00FF, 4'h0);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (result !== e.r) begin
      $display("FAIL latency_first: got %h want %h", result, e.r);
      n_bad++;
    end
    // Opcode changes just after the edge; register must not follow until the next edge
    opcode = 4'h1;
    sb_q.push_back(model(a, b, opcode));
    #2;
    n_cmp++;
    if (result !== e.r) begin
      $display("FAIL latency_mid_cycle: got %h want %h", result, e.r);
      n_bad++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (result !== e.r) begin
      $display("FAIL latency_next_edge: got %h want %h", result, e.r);
      n_bad++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({result, carry, overflow} !== {e.r, e.c, e.v}) begin
        $display("FAIL hold cycle %0d: got %h/%b/%b want %h/%b/%b",
                 i, result, carry, overflow, e.r, e.c, e.v);
        n_bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [11:0] sel_exp;
    for (int i = 0; i < 40; i++) begin
      drive(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      sel_exp = model_sel(opcode);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({result, carry, overflow, select} !== {e.r, e.c, e.v, sel_exp}) begin
        $display("FAIL b2b %0d op=%h a=%h b=%h: got %h/%b/%b sel %h want %h/%b/%b sel %h",
                 i, opcode, a, b, result, carry, overflow, select, e.r, e.c, e.v, sel_exp);
        n_bad++;
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    a      = '0;
    b      = '0;
    opcode = '0;
    test_reset();
    test_logic();
    test_arith();
    test_shift();
    test_clear();
    test_latency_hold();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu16_accum_datapath.md
Name: alu16_accum_datapath

Overview:
- 16-bit combinational ALU with 12 operations, selected by a 4-bit opcode.
- The result is captured into a 16-bit accumulator register on every rising clock edge, together with carry and overflow flags.
- Sits between operand/opcode sources and downstream consumers. It is the top-level datapath of the ALU subsystem and also exports the decoded one-hot operation select.

Parameters:
- WIDTH, 16, operand/result width in bits; the opcode and select encodings below are fixed regardless of WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, the only operand for NOT/shift
- b  input  WIDTH  operand B
- opcode  input  4  operation code
- select  output  12  one-hot decoded operation, combinational from opcode
- result  output  WIDTH  accumulator register contents
- carry  output  1  registered carry-out of ADD/SUB
- overflow  output  1  registered signed overflow of ADD/SUB

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: result=0, carry=0, overflow=0, regardless of clk.
  - Reset release takes effect at the next rising edge.
- Opcode map and select bit:
  - 0000 AND a&b, select[0]
  - 0001 OR a|b, select[1]
  - 0010 NOT ~a, select[2]
  - 0011 XOR a^b, select[3]
  - 0100 NAND ~(a&b), select[4]
  - 0101 NOR ~(a|b), select[5]
  - 0110 XNOR ~(a^b), select[6]
  - 1000 ADD a+b, select[7]
  - 1001 SUB a-b, select[8]
  - 1010 SHR a>>1 (logical, MSB filled with 0), select[9]
  - 1011 SHL a<<1 (LSB filled with 0), select[10]
  - 1111 CLEAR, result 0, select[11]
- Unused opcodes 0111, 1100, 1101, 1110 behave exactly as CLEAR, including select[11]=1.
- select is always exactly one-hot.
- Arithmetic:
  - SUB computed as a + ~b + 1.
  - carry = bit WIDTH of the unsigned sum. For SUB, carry=1 means no borrow (a>=b unsigned).
  - overflow = operands' sign bits (b inverted for SUB) equal and result sign differs.
  - Results wrap modulo 2^WIDTH.
- Flags: for non-arithmetic opcodes, carry and overflow are registered as 0.
- Latency:
  - The operation is combinational from a, b, opcode.
  - result/carry/overflow update on the rising edge following input setup, i.e. 1-cycle latency.
  - Registered values hold while inputs are stable; there is no enable.
- Inputs changing mid-cycle affect only the value sampled at the next edge.
- Asynchronous reset asserted mid-operation clears the registers immediately. The next edge after release loads the current ALU value.
- No X propagation from unused opcodes; all outputs are always defined.

Test Plan:
- Reset: rst_n=0 with a=FFFF, opcode=ADD -> result=0000, carry=0, overflow=0 immediately. Release rst_n, then one edge later -> result reflects the ALU output.
- Logic ops (check each one cycle after apply):
  - AND a=C001, b=8001 -> 8001
  - OR a=0002, b=0001 -> 0003
  - NOT a=4002 -> BFFD
  - XOR a=4002, b=0003 -> 4001
  - NAND a=0002, b=0003 -> FFFD
  - NOR a=0002, b=0003 -> FFFC
  - XNOR a=0002, b=0003 -> FFFE
- Arithmetic:
  - ADD a=0002, b=0003 -> result 0005, carry 0, overflow 0
  - SUB a=0002, b=0003 -> FFFF, carry 0
  - ADD 7FFF+0001 -> 8000, overflow 1
  - ADD FFFF+0001 -> 0000, carry 1
- Shifts: SHR a=0002 -> 0001; SHL a=0002 -> 0004; SHL a=8001 -> 0002; SHR a=8001 -> 4000.
- Clear/unused: opcode 1111 after a nonzero result -> 0000, select=800. Opcode 1101 -> 0000, select=800. Opcode 1001 -> select=100.
- Latency/hold: change opcode just after an edge -> result unchanged until the next rising edge. Hold inputs for 3 cycles -> result constant.
